// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage between execute and write-back.
//            Holds the EX/MEM pipeline register, aligns and sign/zero-extends
//            load data, selects the final stage result and drives forwarding,
//            store-suppression and handshake signals back toward execute.
// Config   : MEM_RDATA_HOLD_EN - when defined, a one-entry hold buffer keeps
//            the first-cycle data-RAM read data and multiplier result while
//            write-back stalls. When undefined, both always come straight
//            from the ports.
// Ports    : clk, reset (sync, active-high)
//            ex_*            - instruction fields and handshake from execute
//            mem_allow_in    - stage can accept an instruction this cycle
//            wb_allow_in     - write-back accepts this cycle
//            mem_flush       - cancel from write-back, kills stage contents
//            mul_result      - multiplier output (valid first occupied cycle)
//            data_sram_rdata - data RAM read data (valid first occupied cycle)
//            wb_*            - instruction offered to write-back
//            mem_fwd_*       - forwarding info toward execute
//            st_disable      - suppresses stores in execute
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
   parameter int PASS_W = 81
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              ex_ready_go,
   output logic              mem_allow_in,
   input  logic              wb_allow_in,
   input  logic              mem_flush,
   input  logic [31:0]       ex_pc,
   input  logic [31:0]       ex_result,
   input  logic              ex_mul,
   input  logic              ex_res_from_mem,
   input  logic [4:0]        ex_ld_ctrl,
   input  logic              ex_rf_we,
   input  logic [4:0]        ex_rf_waddr,
   input  logic [15:0]       ex_ebus,
   input  logic              ex_ertn,
   input  logic [PASS_W-1:0] ex_pass,
   input  logic [31:0]       mul_result,
   input  logic [31:0]       data_sram_rdata,
   output logic              wb_valid,
   output logic [31:0]       wb_pc,
   output logic [31:0]       wb_result,
   output logic              wb_rf_we,
   output logic [4:0]        wb_rf_waddr,
   output logic [15:0]       wb_ebus,
   output logic              wb_ertn,
   output logic [PASS_W-1:0] wb_pass,
   output logic              mem_fwd_we,
   output logic [4:0]        mem_fwd_waddr,
   output logic [31:0]       mem_fwd_data,
   output logic              mem_fwd_is_csr,
   output logic              st_disable
);

   // ------------------------------------------------------------------------
   // Pipeline register
   // ------------------------------------------------------------------------
   logic              r_valid;
   logic [31:0]       r_pc;
   logic [31:0]       r_result;
   logic              r_mul;
   logic              r_res_from_mem;
   logic [4:0]        r_ld_ctrl;
   logic              r_rf_we;
   logic [4:0]        r_rf_waddr;
   logic [15:0]       r_ebus;
   logic              r_ertn;
   logic [PASS_W-1:0] r_pass;

   logic              w_load;
   logic              w_exc;
   logic [31:0]       w_rd;
   logic [31:0]       w_mr;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_data;
   logic [31:0]       w_final;

   // This stage always completes in one cycle, so acceptance only depends
   // on whether the current occupant can leave.
   assign mem_allow_in = ~r_valid | wb_allow_in;
   assign w_load       = ex_valid & ex_ready_go & mem_allow_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
      end else if (mem_flush) begin
         // Flush wins over an instruction arriving in the same cycle.
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
      end else if (wb_allow_in) begin
         r_valid <= 1'b0;
      end
   end

   // Data fields carry no reset; they are qualified by r_valid.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_pc           <= ex_pc;
         r_result       <= ex_result;
         r_mul          <= ex_mul;
         r_res_from_mem <= ex_res_from_mem;
         r_ld_ctrl      <= ex_ld_ctrl;
         r_rf_we        <= ex_rf_we;
         r_rf_waddr     <= ex_rf_waddr;
         r_ebus         <= ex_ebus;
         r_ertn         <= ex_ertn;
         r_pass         <= ex_pass;
      end
   end

   // ------------------------------------------------------------------------
   // Read-data / multiplier source select
   // ------------------------------------------------------------------------
`ifdef MEM_RDATA_HOLD_EN
   logic        r_first;
   logic        r_hold_vld;
   logic [31:0] r_hold_rdata;
   logic [31:0] r_hold_mul;
   logic        w_capture;

   // The RAM and multiplier only present their result in the first occupied
   // cycle, so snapshot them if write-back is not taking the instruction.
   assign w_capture = r_valid & r_first & ~wb_allow_in;

   always_ff @(posedge clk) begin
      if (reset || mem_flush) begin
         r_first    <= 1'b0;
         r_hold_vld <= 1'b0;
      end else if (w_load) begin
         r_first    <= 1'b1;
         r_hold_vld <= 1'b0;
      end else begin
         r_first <= 1'b0;
         if (w_capture) begin
            r_hold_vld <= 1'b1;
         end else if (r_valid && wb_allow_in) begin
            r_hold_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_hold_rdata <= data_sram_rdata;
         r_hold_mul   <= mul_result;
      end
   end

   assign w_rd = r_hold_vld ? r_hold_rdata : data_sram_rdata;
   assign w_mr = r_hold_vld ? r_hold_mul   : mul_result;
`else
   assign w_rd = data_sram_rdata;
   assign w_mr = mul_result;
`endif

   // ------------------------------------------------------------------------
   // Load alignment and extension; r_result[1:0] is the byte offset.
   // r_ld_ctrl = {ld_w, ld_bu, ld_b, ld_hu, ld_h}
   // ------------------------------------------------------------------------
   always_comb begin
      w_byte      = w_rd[{r_result[1:0], 3'b000} +: 8];
      w_half      = r_result[1] ? w_rd[31:16] : w_rd[15:0];
      w_load_data = 32'h0;
      if (r_ld_ctrl[4]) begin
         w_load_data = w_rd;
      end else if (r_ld_ctrl[2]) begin
         w_load_data = {{24{w_byte[7]}}, w_byte};
      end else if (r_ld_ctrl[3]) begin
         w_load_data = {24'h0, w_byte};
      end else if (r_ld_ctrl[0]) begin
         w_load_data = {{16{w_half[15]}}, w_half};
      end else if (r_ld_ctrl[1]) begin
         w_load_data = {16'h0, w_half};
      end
   end

   assign w_final = r_res_from_mem ? w_load_data :
                    r_mul          ? w_mr        : r_result;

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign w_exc          = |r_ebus;

   assign wb_valid       = r_valid;
   assign wb_pc          = r_pc;
   assign wb_result      = w_final;
   assign wb_rf_we       = r_rf_we & r_valid & ~w_exc;
   assign wb_rf_waddr    = r_rf_waddr;
   assign wb_ebus        = r_ebus;
   assign wb_ertn        = r_ertn;
   assign wb_pass        = r_pass;

   assign mem_fwd_we     = wb_rf_we;
   assign mem_fwd_waddr  = r_rf_waddr;
   assign mem_fwd_data   = w_final;
   // Low bit of the pass-through field is res_from_csr.
   assign mem_fwd_is_csr = r_pass[0];

   // An excepting or ertn instruction here means younger stores must not
   // reach memory.
   assign st_disable     = r_valid & (w_exc | r_ertn);

endmodule

`default_nettype wire
